// File: rtl/perf_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_counter_bank                                                |
// | Brief   : Bank of independent event counters with per-channel mode,        |
// |           compare, overflow and match, plus indexed write/registered read. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module perf_counter_bank #(
   parameter int WIDTH    = 32,
   parameter int CH_W     = 2,
   localparam int CHANNELS = 2 ** CH_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] inc_i,
   input  logic [CHANNELS-1:0] inhibit_i,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_sel,
   input  logic [1:0]          wr_field,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic [CH_W-1:0]     rd_sel,
   input  logic [1:0]          rd_field,
   output logic [WIDTH-1:0]    rd_data,
   output logic [CHANNELS-1:0] match_o,
   output logic [CHANNELS-1:0] ovf_o
);

   localparam logic [1:0] c_MODE_WRAP    = 2'b00;
   localparam logic [1:0] c_MODE_SAT     = 2'b01;
   localparam logic [1:0] c_MODE_RELOAD  = 2'b10;
   localparam logic [1:0] c_MODE_ONESHOT = 2'b11;

   localparam logic [1:0] c_F_COUNT   = 2'b00;
   localparam logic [1:0] c_F_COMPARE = 2'b01;
   localparam logic [1:0] c_F_MODE    = 2'b10;
   localparam logic [1:0] c_F_STATUS  = 2'b11;

   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]    w_cnt  [CHANNELS];
   logic [WIDTH-1:0]    w_cmp  [CHANNELS];
   logic [1:0]          w_mode [CHANNELS];
   logic [CHANNELS-1:0] w_done;
   logic [CHANNELS-1:0] w_ovf;
   logic [CHANNELS-1:0] w_match;
   logic [WIDTH-1:0]    r_rd_data;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [WIDTH-1:0] r_cnt;
      logic [WIDTH-1:0] r_cmp;
      logic [1:0]       r_mode;
      logic             r_done;
      logic             r_ovf;
      logic             r_match;
      logic             w_sel;
      logic             w_ev;
      logic             w_hit;
      logic             w_max;
      logic             w_cnt_wr;
      logic [WIDTH-1:0] w_inc;

      assign w_sel    = wr_en && (wr_sel == CH_W'(n));
      assign w_cnt_wr = w_sel && (wr_field == c_F_COUNT);
      assign w_ev     = inc_i[n] && !inhibit_i[n] && !r_done;
      assign w_hit    = w_ev && (r_cnt == r_cmp);
      assign w_max    = &r_cnt;
      assign w_inc    = r_cnt + c_ONE;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt   <= '0;
            r_cmp   <= '1;
            r_mode  <= c_MODE_WRAP;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_match <= 1'b0;
         end else begin
            r_match <= w_hit && !w_cnt_wr;
            // A count write overrides any event of the same cycle.
            if (w_cnt_wr) begin
               r_cnt  <= wr_data;
               r_ovf  <= 1'b0;
               r_done <= 1'b0;
            end else if (w_ev) begin
               case (r_mode)
                  c_MODE_SAT: begin
                     if (w_max) r_ovf <= 1'b1;
                     else       r_cnt <= w_inc;
                  end
                  c_MODE_RELOAD: begin
                     if (w_hit) begin
                        r_cnt <= '0;
                     end else begin
                        r_cnt <= w_inc;
                        if (w_max) r_ovf <= 1'b1;
                     end
                  end
                  c_MODE_ONESHOT: begin
                     if (w_hit) begin
                        r_done <= 1'b1;
                     end else begin
                        r_cnt <= w_inc;
                        if (w_max) r_ovf <= 1'b1;
                     end
                  end
                  default: begin
                     r_cnt <= w_inc;
                     if (w_max) r_ovf <= 1'b1;
                  end
               endcase
            end
            if (w_sel && (wr_field == c_F_COMPARE)) r_cmp <= wr_data;
            // Placed after event handling so a mode write also clears a done set this cycle.
            if (w_sel && (wr_field == c_F_MODE)) begin
               r_mode <= wr_data[1:0];
               r_done <= 1'b0;
            end
         end
      end

      assign w_cnt[n]   = r_cnt;
      assign w_cmp[n]   = r_cmp;
      assign w_mode[n]  = r_mode;
      assign w_done[n]  = r_done;
      assign w_ovf[n]   = r_ovf;
      assign w_match[n] = r_match;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else begin
         case (rd_field)
            c_F_COUNT:   r_rd_data <= w_cnt[rd_sel];
            c_F_COMPARE: r_rd_data <= w_cmp[rd_sel];
            c_F_MODE:    r_rd_data <= {{(WIDTH-2){1'b0}}, w_mode[rd_sel]};
            c_F_STATUS:  r_rd_data <= {{(WIDTH-2){1'b0}}, w_done[rd_sel], w_ovf[rd_sel]};
            default:     r_rd_data <= '0;
         endcase
      end
   end

   assign rd_data = r_rd_data;
   assign match_o = w_match;
   assign ovf_o   = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_perf_counter_bank                                             |
// | Brief   : Scoreboard bench for perf_counter_bank (WIDTH=8, four channels). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_perf_counter_bank;

   typedef struct {
      logic [7:0] d;
      logic [3:0] m;
      logic [3:0] o;
      logic [3:0] mask;
      string      nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] inc_i, inhibit_i;
   logic       wr_en;
   logic [1:0] wr_sel, wr_field;
   logic [7:0] wr_data;
   logic [1:0] rd_sel, rd_field;
   logic [7:0] rd_data;
   logic [3:0] match_o, ovf_o;

   logic       req  = 1'b0;
   logic       pend = 1'b0;
   exp_t       q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   event       ev_snap;

   perf_counter_bank #(.WIDTH(8), .CH_W(2)) dut (
      .clk(clk), .rst(rst), .inc_i(inc_i), .inhibit_i(inhibit_i),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_field(wr_field), .wr_data(wr_data),
      .rd_sel(rd_sel), .rd_field(rd_field), .rd_data(rd_data),
      .match_o(match_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pend <= req;

   task automatic check_front();
      exp_t e;
      if (q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL underflow: response with empty queue, rd_data=%0d", rd_data);
      end else begin
         e = q.pop_front();
         n_tests++;
         if (rd_data !== e.d || (match_o & e.mask) !== (e.m & e.mask) ||
             (ovf_o & e.mask) !== (e.o & e.mask)) begin
            n_fail++;
            $display("FAIL %s: rd_data=%0d exp %0d, match_o=%b exp %b, ovf_o=%b exp %b (mask %b)",
                     e.nm, rd_data, e.d, match_o, e.m, ovf_o, e.o, e.mask);
         end
      end
   endtask

   always @(negedge clk) if (pend) check_front();
   always @(ev_snap) check_front();

   task automatic tick();
      @(negedge clk);
      wr_en = 1'b0;
      req   = 1'b0;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [1:0] field, input logic [7:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_field = field; wr_data = d;
   endtask

   task automatic rd(input logic [1:0] sel, input logic [1:0] field, input logic [7:0] d,
                     input logic [3:0] m, input logic [3:0] o, input logic [3:0] mask,
                     input string nm);
      exp_t e;
      rd_sel = sel; rd_field = field; req = 1'b1;
      e.d = d; e.m = m; e.o = o; e.mask = mask; e.nm = nm;
      q.push_back(e);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete, required completion");
      $fatal(1);
   end

   initial begin
      exp_t s;
      rst = 1'b1; inc_i = '0; inhibit_i = '0; wr_en = 1'b0;
      wr_sel = '0; wr_field = '0; wr_data = '0; rd_sel = '0; rd_field = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset values
      rd(0, 0, 8'd0,   4'h0, 4'h0, 4'hF, "rst_count0");   tick();
      rd(0, 1, 8'hFF,  4'h0, 4'h0, 4'hF, "rst_cmp0");     tick();
      rd(1, 2, 8'd0,   4'h0, 4'h0, 4'hF, "rst_mode1");    tick();
      rd(3, 3, 8'd0,   4'h0, 4'h0, 4'hF, "rst_status3");  tick();

      // WRAP on channel 0: 257 increments
      inc_i[0] = 1'b1;
      for (int i = 0; i <= 256; i++) begin
         rd(0, 0, i[7:0], (i == 255) ? 4'h1 : 4'h0, (i >= 255) ? 4'h1 : 4'h0, 4'h1, "wrap");
         tick();
      end
      inc_i[0] = 1'b0;

      // SAT and inhibit on channel 1
      wr(1, 2, 8'd1);   tick();
      wr(1, 0, 8'd253); tick();
      inc_i[1] = 1'b1;
      rd(1, 0, 8'd253, 4'h0, 4'h0, 4'h2, "sat_253"); tick();
      rd(1, 0, 8'd254, 4'h0, 4'h0, 4'h2, "sat_254"); tick();
      rd(1, 0, 8'd255, 4'h2, 4'h2, 4'h2, "sat_255a"); tick();
      rd(1, 0, 8'd255, 4'h2, 4'h2, 4'h2, "sat_255b"); tick();
      rd(1, 0, 8'd255, 4'h2, 4'h2, 4'h2, "sat_255c"); tick();
      inhibit_i[1] = 1'b1;
      wr(1, 0, 8'd10);
      rd(1, 0, 8'd255, 4'h0, 4'h0, 4'h2, "inh_wr_old"); tick();
      rd(1, 0, 8'd10,  4'h0, 4'h0, 4'h2, "inh_10a");    tick();
      rd(1, 0, 8'd10,  4'h0, 4'h0, 4'h2, "inh_10b");    tick();
      rd(1, 3, 8'd0,   4'h0, 4'h0, 4'h2, "inh_status"); tick();
      inc_i[1] = 1'b0; inhibit_i[1] = 1'b0;

      // RELOAD on channel 2, period 5
      wr(2, 1, 8'd4); tick();
      wr(2, 2, 8'd2); tick();
      inc_i[2] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         rd(2, 0, 8'(i % 5), (i % 5 == 4) ? 4'h4 : 4'h0, 4'h0, 4'h4, "reload");
         tick();
      end
      inc_i[2] = 1'b0;

      // ONESHOT on channel 3
      wr(3, 1, 8'd3); tick();
      wr(3, 2, 8'd3); tick();
      inc_i[3] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd(3, 0, (i < 3) ? 8'(i) : 8'd3, (i == 3) ? 4'h8 : 4'h0, 4'h0, 4'h8, "oneshot");
         tick();
      end
      rd(3, 3, 8'd2, 4'h0, 4'h0, 4'h8, "os_status_done"); tick();
      wr(3, 1, 8'd6);
      rd(3, 1, 8'd3, 4'h0, 4'h0, 4'h8, "os_cmp_rdw_old"); tick();
      wr(3, 2, 8'd3);
      rd(3, 3, 8'd2, 4'h0, 4'h0, 4'h8, "os_rearm"); tick();
      for (int i = 0; i < 5; i++) begin
         rd(3, 0, (i < 3) ? 8'(3 + i) : 8'd6, (i == 3) ? 4'h8 : 4'h0, 4'h0, 4'h8, "os_resume");
         tick();
      end
      inc_i[3] = 1'b0;
      rd(3, 3, 8'd2, 4'h0, 4'h0, 4'h8, "os_done_again"); tick();

      // Write/increment collision and read-during-write on channel 0
      inc_i[0] = 1'b1;
      wr(0, 0, 8'd100);
      rd(0, 0, 8'd1, 4'h0, 4'h0, 4'h1, "coll_old"); tick();
      inc_i[0] = 1'b0;
      rd(0, 0, 8'd100, 4'h0, 4'h0, 4'h1, "coll_new"); tick();
      rd(0, 0, 8'd100, 4'h0, 4'h0, 4'h1, "coll_hold"); tick();
      rd(1, 0, 8'd10,  4'h0, 4'h0, 4'hF, "iso_ch1");   tick();
      rd(2, 0, 8'd2,   4'h0, 4'h0, 4'hF, "iso_ch2");   tick();

      // Async reset mid-count with live flags
      inc_i = 4'b0001;
      wr(1, 0, 8'd255);
      rd(0, 0, 8'd100, 4'h0, 4'h0, 4'h0, "pre_rst_a"); tick();
      inc_i = 4'b0011;
      rd(0, 0, 8'd101, 4'h2, 4'h2, 4'h2, "pre_rst_b"); tick();
      #2 rst = 1'b1;
      inc_i = 4'b0000;
      #1;
      s.d = 8'd0; s.m = 4'h0; s.o = 4'h0; s.mask = 4'hF; s.nm = "async_rst";
      q.push_back(s);
      -> ev_snap;
      tick(); tick();
      rst = 1'b0;
      inc_i = 4'b0001;
      rd(0, 0, 8'd0,   4'h0, 4'h0, 4'hF, "post_rst_c0a");  tick();
      inc_i = 4'b0000;
      rd(0, 0, 8'd1,   4'h0, 4'h0, 4'hF, "post_rst_c0b");  tick();
      rd(1, 0, 8'd0,   4'h0, 4'h0, 4'hF, "post_rst_c1");   tick();
      rd(1, 2, 8'd0,   4'h0, 4'h0, 4'hF, "post_rst_mode1"); tick();
      rd(2, 1, 8'hFF,  4'h0, 4'h0, 4'hF, "post_rst_cmp2"); tick();
      rd(3, 3, 8'd0,   4'h0, 4'h0, 4'hF, "post_rst_st3");  tick();

      for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of independent event counters, generalising the single free-running 32-bit counter.
- Each channel has its own width-configurable count, compare register, mode (wrap / saturate / reload / one-shot), inhibit, overflow flag and match pulse.
- Sits beside the core as the cycle/instret/hpm counter source. It has a simple indexed write port and a registered read port for the CSR unit.

Parameters:
- WIDTH, 32, counter and compare register width in bits (>=4).
- CH_W, 2, channel index width; channel count CHANNELS = 2**CH_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- inc_i  in  CHANNELS  per-channel increment event; bit n drives channel n.
- inhibit_i  in  CHANNELS  per-channel hold; when 1, inc_i is ignored.
- wr_en  in  1  write strobe.
- wr_sel  in  CH_W  channel to write.
- wr_field  in  2  00 count, 01 compare, 10 mode, 11 reserved (ignored).
- wr_data  in  WIDTH  write data; mode uses bits [1:0].
- rd_sel  in  CH_W  channel to read.
- rd_field  in  2  00 count, 01 compare, 10 mode, 11 status.
- rd_data  out  WIDTH  registered read data.
- match_o  out  CHANNELS  one-cycle compare-event pulse per channel.
- ovf_o  out  CHANNELS  sticky overflow/saturation flag per channel.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values, all channels:
  - count = 0
  - compare = all ones
  - mode = 00 (WRAP)
  - done = 0, ovf_o = 0, match_o = 0, rd_data = 0
- Effective event: E[n] = inc_i[n] & ~inhibit_i[n] & ~done[n]. At most one increment per channel per cycle.
- Compare hit: H[n] = E[n] & (count[n] == compare[n]). When H is true, match_o[n] = 1 on the next cycle for exactly one cycle; otherwise 0.
- Mode 00 WRAP:
  - On E, count <= count+1 mod 2**WIDTH.
  - If count was all ones, count becomes 0 and ovf <= 1.
- Mode 01 SAT:
  - On E with count < max, count <= count+1.
  - On E with count == all ones, count holds and ovf <= 1.
- Mode 10 RELOAD:
  - On H, count <= 0.
  - Otherwise on E, count increments as in WRAP, including setting ovf on wrap.
- Mode 11 ONESHOT:
  - On H, count holds and done <= 1.
  - While done = 1, the channel ignores all events.
  - Otherwise on E, count increments as in WRAP.
- Match in WRAP/SAT: H still pulses match_o, and count advances normally.
- Writes take effect on the next edge and affect only the selected channel.
  - count write: loads wr_data, clears ovf and done, and suppresses any same-cycle increment and match of that channel (write wins).
  - compare write: loads compare. The same-cycle hit test uses the old compare.
  - mode write: loads wr_data[1:0] and clears done. The same-cycle event is processed under the old mode.
- Status read: rd_data = {zero pad, done, ovf} with ovf in bit 0 and done in bit 1.
- Read: rd_data is registered with 1-cycle latency. It returns the selected field as it was before that cycle's update, so read-during-write returns the old value.
- Other channels are never affected by a write or read.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. Counting resumes on the first edge after release.

Test Plan:
- Reset and WRAP wrap-around: WIDTH=8, rst 1→0, inc_i[0]=1 for 256 cycles → count0 0..255 then 0; ovf_o[0] rises the cycle after the wrap; match_o[0] pulses one cycle after count0==255 is incremented (compare=255).
- SAT and inhibit: channel1 mode=01, count written to 253, inc for 5 cycles → 254, 255, 255, 255; ovf_o[1]=1. Then inhibit_i[1]=1 with a count write of 10 → count=10, ovf cleared, no further change.
- RELOAD period: channel2 mode=10, compare=4, continuous inc → count 0, 1, 2, 3, 4, 0, 1, …; match_o[2] pulses every 5th cycle; ovf_o[2] stays 0.
- ONESHOT: channel3 mode=11, compare=3, continuous inc → count stops at 3, single match pulse, status read = 2'b10. A mode rewrite to 11 clears done and counting resumes at 4.
- Write/increment collision and read latency: inc_i[0]=1 while writing count0=100 → next count0=100, not 101. A read of count0 issued in the same cycle returns the pre-write value one cycle later; the following read returns 100.
- Async reset mid-count: assert rst between clock edges with counts non-zero → all counts, flags and rd_data are 0 before the next edge.
